// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and constants for the two-requester FP32 multiplier arbiter.
package fp_mul_pkg;
    localparam int FP32_W  = 32;
    localparam int NUM_REQ = 2;

    typedef logic tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } pipe_entry_t;
endpackage

// File: rtl/fp_mul_tag_pipe.sv
// fp_mul_tag_pipe: non-stalling shift register that tracks which requester owns each multiplier slot.
module fp_mul_tag_pipe
    import fp_mul_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pipe_entry_t in_i,
    output pipe_entry_t out_o
);
    pipe_entry_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one pipelined FP32 multiplier between two requesters,
// with one outstanding operation per requester and a one-entry response buffer each.
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int WIDTH       = FP32_W,
    parameter int MUL_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_in_valid,
    input  logic [WIDTH-1:0] mul_c,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             busy
);
    logic [NUM_REQ-1:0]            cand, grant, rsp_hs;
    logic [NUM_REQ-1:0]            out_q, out_d, rsp_vld_q, rsp_vld_d;
    logic [NUM_REQ-1:0][WIDTH-1:0] rsp_c_q;
    logic [WIDTH-1:0]              mul_a_q, mul_b_q;
    logic                          rr_q, rr_d, mul_vld_q, busy_q, accept;
    tag_t                          gnt_idx;
    pipe_entry_t                   pipe_in, pipe_out;

    // A requester with an operation still in flight or unconsumed is never offered ready.
    always_comb begin
        cand      = {req1_valid, req0_valid} & ~out_q;
        grant[0]  = cand[0] && (!cand[1] || !rr_q);
        grant[1]  = cand[1] && !grant[0];
        accept    = |grant;
        gnt_idx   = grant[1];
        rsp_hs    = rsp_vld_q & {rsp1_ready, rsp0_ready};
        rr_d      = accept ? !gnt_idx : rr_q;
        out_d     = (out_q | grant) & ~rsp_hs;
        pipe_in.valid = accept;
        pipe_in.tag   = gnt_idx;
        rsp_vld_d = (rsp_vld_q & ~rsp_hs) | (pipe_out.valid ? (2'b01 << pipe_out.tag) : 2'b00);
    end

    fp_mul_tag_pipe #(.DEPTH(MUL_LATENCY)) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (pipe_in),
        .out_o (pipe_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= 1'b0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            mul_vld_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            rsp_vld_q <= '0;
            rsp_c_q   <= '0;
        end else begin
            rr_q      <= rr_d;
            out_q     <= out_d;
            busy_q    <= |out_d;
            mul_vld_q <= accept;
            rsp_vld_q <= rsp_vld_d;
            if (accept) begin
                mul_a_q <= gnt_idx ? req1_a : req0_a;
                mul_b_q <= gnt_idx ? req1_b : req0_b;
            end
            // The owning buffer is always empty here: its requester cannot reissue until it drains.
            if (pipe_out.valid) rsp_c_q[pipe_out.tag] <= mul_c;
        end
    end

    assign req0_ready   = grant[0];
    assign req1_ready   = grant[1];
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_in_valid = mul_vld_q;
    assign rsp0_valid   = rsp_vld_q[0];
    assign rsp1_valid   = rsp_vld_q[1];
    assign rsp0_c       = rsp_c_q[0];
    assign rsp1_c       = rsp_c_q[1];
    assign busy         = busy_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: two arbiter instances (latency 1 and 3) with multiplier models,
// checked every cycle against a transaction-level model of each requester's life cycle.
module tb_fp_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv  [2][2];
    logic        rr  [2][2];
    logic        rsv [2][2];
    logic        rsr [2][2];
    logic [31:0] ra  [2][2];
    logic [31:0] rb  [2][2];
    logic [31:0] rsc [2][2];
    logic [31:0] ma [2], mb [2], mc [2];
    logic        miv [2], bsy [2];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Normal-number truncating multiply: exact for the directed vectors, deterministic for any bits.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (m[47]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_env
        logic [31:0] s1, s2;

        fp_mul_arbiter #(.MUL_LATENCY(g == 0 ? 1 : 3)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req0_valid   (rv[g][0]),
            .req0_ready   (rr[g][0]),
            .req0_a       (ra[g][0]),
            .req0_b       (rb[g][0]),
            .req1_valid   (rv[g][1]),
            .req1_ready   (rr[g][1]),
            .req1_a       (ra[g][1]),
            .req1_b       (rb[g][1]),
            .mul_a        (ma[g]),
            .mul_b        (mb[g]),
            .mul_in_valid (miv[g]),
            .mul_c        (mc[g]),
            .rsp0_valid   (rsv[g][0]),
            .rsp0_ready   (rsr[g][0]),
            .rsp0_c       (rsc[g][0]),
            .rsp1_valid   (rsv[g][1]),
            .rsp1_ready   (rsr[g][1]),
            .rsp1_c       (rsc[g][1]),
            .busy         (bsy[g])
        );

        always @(posedge clk) begin
            s1 <= fmul(ma[g], mb[g]);
            s2 <= s1;
        end
        assign mc[g] = (g == 0) ? fmul(ma[g], mb[g]) : s2;
    end

    // Reference model: each requester is idle (0), in flight (1) or holding a result (2).
    int          st   [2][2];
    int          cnt  [2][2];
    logic [31:0] val  [2][2];
    int          pref [2];
    logic        emiv [2];
    logic [31:0] ema [2], emb [2];
    logic        mg [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int r = 0; r < 2; r++) st[d][r] = 0;
                pref[d] = 0;
                emiv[d] = 1'b0;
                ema[d]  = '0;
                emb[d]  = '0;
            end
            for (int r = 0; r < 2; r++) mg[r] = rv[d][r] && st[d][r] == 0;
            if (mg[0] && mg[1]) begin
                mg[0] = (pref[d] == 0);
                mg[1] = (pref[d] == 1);
            end
            for (int r = 0; r < 2; r++) begin
                chk($sformatf("d%0d_ready%0d", d, r), 32'(rr[d][r]), 32'(mg[r]));
                chk($sformatf("d%0d_rspv%0d", d, r), 32'(rsv[d][r]), 32'(st[d][r] == 2));
                if (st[d][r] == 2) chk($sformatf("d%0d_rspc%0d", d, r), rsc[d][r], val[d][r]);
            end
            chk($sformatf("d%0d_busy", d), 32'(bsy[d]), 32'(st[d][0] != 0 || st[d][1] != 0));
            chk($sformatf("d%0d_miv", d), 32'(miv[d]), 32'(emiv[d]));
            chk($sformatf("d%0d_mul_a", d), ma[d], ema[d]);
            chk($sformatf("d%0d_mul_b", d), mb[d], emb[d]);
            if (rst_n) begin
                for (int r = 0; r < 2; r++) begin
                    if (st[d][r] == 2 && rsr[d][r]) st[d][r] = 0;
                    else if (st[d][r] == 1) begin
                        cnt[d][r]--;
                        if (cnt[d][r] == 0) st[d][r] = 2;
                    end
                end
                emiv[d] = mg[0] || mg[1];
                for (int r = 0; r < 2; r++) if (mg[r]) begin
                    st[d][r]  = 1;
                    cnt[d][r] = (d == 0) ? 1 : 3;
                    val[d][r] = fmul(ra[d][r], rb[d][r]);
                    ema[d]    = ra[d][r];
                    emb[d]    = rb[d][r];
                    pref[d]   = 1 - r;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) rv[d][r] = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        int          seq [$];
        int          zeros;
        bit          seen;
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) begin
            rv[d][r] = 1'b0; rsr[d][r] = 1'b0; ra[d][r] = '0; rb[d][r] = '0;
        end
        tick();
        tick();
        rst_n = 1'b1;

        // Single operation, held response.
        rv[0][0] = 1'b1; ra[0][0] = 32'h3FC00000; rb[0][0] = 32'hC0400000;
        tick();
        chk("t1_miv", 32'(miv[0]), 32'd1);
        chk("t1_mul_a", ma[0], 32'h3FC00000);
        chk("t1_busy", 32'(bsy[0]), 32'd1);
        rv[0][0] = 1'b0;
        tick();
        chk("t1_rspv", 32'(rsv[0][0]), 32'd1);
        chk("t1_rspc", rsc[0][0], 32'hC0900000);
        chk("t1_miv_pulse", 32'(miv[0]), 32'd0);
        tick();
        chk("t1_busy_held", 32'(bsy[0]), 32'd1);
        rsr[0][0] = 1'b1;
        tick();
        chk("t1_rspv_done", 32'(rsv[0][0]), 32'd0);
        chk("t1_busy_done", 32'(bsy[0]), 32'd0);

        // Contention after reset: requester 0 first.
        do_reset();
        rsr[0][0] = 1'b1; rsr[0][1] = 1'b1;
        rv[0][0] = 1'b1; ra[0][0] = 32'h3FC00000; rb[0][0] = 32'hC0400000;
        rv[0][1] = 1'b1; ra[0][1] = 32'hC0300000; rb[0][1] = 32'h40000000;
        #1;
        chk("t2_ready0", 32'(rr[0][0]), 32'd1);
        chk("t2_ready1", 32'(rr[0][1]), 32'd0);
        tick();
        rv[0][0] = 1'b0;
        #1;
        chk("t2_ready1_next", 32'(rr[0][1]), 32'd1);
        tick();
        rv[0][1] = 1'b0;
        chk("t2_rsp0", rsc[0][0], 32'hC0900000);
        tick();
        chk("t2_rsp1v", 32'(rsv[0][1]), 32'd1);
        chk("t2_rsp1", rsc[0][1], 32'hC0B00000);
        tick();

        // Backpressure on requester 0.
        rsr[0][0] = 1'b0;
        rv[0][0] = 1'b1; ra[0][0] = $urandom; rb[0][0] = $urandom;
        tick();
        ra[0][0] = $urandom; rb[0][0] = $urandom;
        tick();
        held = rsc[0][0];
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready_low", 32'(rr[0][0]), 32'd0);
            chk("t3_rsp_stable", rsc[0][0], held);
            tick();
        end
        rsr[0][0] = 1'b1;
        #1;
        chk("t3_ready_hs_cycle", 32'(rr[0][0]), 32'd0);
        tick();
        chk("t3_rsp_drained", 32'(rsv[0][0]), 32'd0);
        chk("t3_reaccept", 32'(rr[0][0]), 32'd1);
        tick();
        chk("t3_issue_a", ma[0], ra[0][0]);
        rv[0][0] = 1'b0;
        tick();
        tick();

        // Fairness under continuous contention.
        do_reset();
        rsr[0][0] = 1'b1; rsr[0][1] = 1'b1;
        rv[0][0] = 1'b1; rv[0][1] = 1'b1;
        for (int i = 0; i < 100 && seq.size() < 8; i++) begin
            for (int r = 0; r < 2; r++) begin ra[0][r] = $urandom; rb[0][r] = $urandom; end
            #1;
            for (int r = 0; r < 2; r++) if (rv[0][r] && rr[0][r]) seq.push_back(r);
            tick();
        end
        rv[0][0] = 1'b0; rv[0][1] = 1'b0;
        chk("t4_issues", 32'(seq.size()), 32'd8);
        zeros = 0;
        foreach (seq[i]) begin
            chk($sformatf("t4_order%0d", i), 32'(seq[i]), 32'(i % 2));
            if (seq[i] == 0) zeros++;
        end
        chk("t4_share0", 32'(zeros), 32'd4);
        tick();
        tick();
        tick();

        // Latency 3, back-to-back issue.
        rsr[1][0] = 1'b1; rsr[1][1] = 1'b1;
        rv[1][0] = 1'b1; ra[1][0] = 32'h3FC00000; rb[1][0] = 32'hC0400000;
        tick();
        rv[1][0] = 1'b0;
        rv[1][1] = 1'b1; ra[1][1] = 32'hC0300000; rb[1][1] = 32'h40000000;
        tick();
        rv[1][1] = 1'b0;
        chk("t5_mul_a1", ma[1], 32'hC0300000);
        tick();
        chk("t5_rsp0_early", 32'(rsv[1][0]), 32'd0);
        tick();
        chk("t5_rsp0v", 32'(rsv[1][0]), 32'd1);
        chk("t5_rsp0c", rsc[1][0], 32'hC0900000);
        chk("t5_rsp1_early", 32'(rsv[1][1]), 32'd0);
        tick();
        chk("t5_rsp1v", 32'(rsv[1][1]), 32'd1);
        chk("t5_rsp1c", rsc[1][1], 32'hC0B00000);
        tick();

        // Reset with an operation in flight.
        rv[1][1] = 1'b1; ra[1][1] = $urandom; rb[1][1] = $urandom;
        tick();
        rv[1][1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_mul_a", ma[1], 32'h0);
        chk("t6_mul_b", mb[1], 32'h0);
        chk("t6_busy", 32'(bsy[1]), 32'd0);
        chk("t6_rspv1", 32'(rsv[1][1]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("t6_no_stale", 32'(rsv[1][1]), 32'd0);
            tick();
        end
        rv[1][1] = 1'b1; ra[1][1] = 32'h3FC00000; rb[1][1] = 32'h40000000;
        tick();
        rv[1][1] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (rsv[1][1]) begin
                seen = 1'b1;
                chk("t6_new_rsp", rsc[1][1], 32'h40400000);
            end
        end
        if (!seen) chk("t6_new_rsp_timeout", 32'd0, 32'd1);
        tick();

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) begin
                rv[d][r]  = $urandom_range(0, 2) != 0;
                rsr[d][r] = $urandom_range(0, 1) != 0;
                ra[d][r]  = $urandom;
                rb[d][r]  = $urandom;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) rv[d][r] = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
